sw_debounce: RTL

//   Upstream conditioning stage for the slide-switch inputs (SW1..SW4) that feed the

---
 rtl/sw_debounce.sv | 106 ++++++++++
 1 files changed

// File: rtl/sw_debounce.sv
// Slide-switch conditioning: 2-FF synchroniser and counter debouncer per channel.
// Produces clean levels plus registered one-clock rise/fall/change pulses.
module sw_debounce #(
  parameter int N_CH       = 4,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic [N_CH-1:0] sw_in,
  output logic [N_CH-1:0] sw_db,
  output logic [N_CH-1:0] sw_rise,
  output logic [N_CH-1:0] sw_fall,
  output logic            sw_change
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEB_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  logic [N_CH-1:0] s1;
  logic [N_CH-1:0] s2;
  logic [N_CH-1:0] db_nx;
  logic [N_CH-1:0] rise_nx;
  logic [N_CH-1:0] fall_nx;

  // Two-stage synchroniser; only s2 feeds the debouncers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_in;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           st;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             db_d;
    logic             rise_d;
    logic             fall_d;

    // A channel counts only while the synced pin disagrees with sw_db;
    // any return to agreement drops the partial count.
    always_comb begin
      st     = (s2[i] != sw_db[i]) ? COUNT : IDLE;
      cnt_d  = '0;
      db_d   = sw_db[i];
      rise_d = 1'b0;
      fall_d = 1'b0;
      unique case (st)
        IDLE: begin
          cnt_d = '0;
        end
        COUNT: begin
          if (cnt_q == CNT_MAX) begin
            db_d   = s2[i];
            rise_d = s2[i];
            fall_d = ~s2[i];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end

    // Per-channel stability counter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign db_nx[i]   = db_d;
    assign rise_nx[i] = rise_d;
    assign fall_nx[i] = fall_d;
  end

  // Registered levels and pulses; change is the OR of this cycle's edges.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sw_db     <= '0;
      sw_rise   <= '0;
      sw_fall   <= '0;
      sw_change <= 1'b0;
    end else begin
      sw_db     <= db_nx;
      sw_rise   <= rise_nx;
      sw_fall   <= fall_nx;
      sw_change <= |(rise_nx | fall_nx);
    end
  end

endmodule
